// File: rtl/mem_loader.sv
// mem_loader
//   Writer-side companion to the read-only memories. Takes a framed byte
//   stream (UART or debug port), assembles little-endian DWIDTH-bit words
//   and writes them into a synchronous RAM through a simple write port.
//
//   Frame: A5 | ADDR_LO ADDR_HI | CNT_LO CNT_HI | N*(DWIDTH/8) data | CSUM
//   The 8-bit sum of every byte after A5, CSUM included, must be 0x00.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_data    incoming byte
//   in_valid   in_data holds a byte
//   in_ready   loader accepts a byte this cycle
//   mem_we     write strobe, one cycle per word
//   mem_addr   write address (holds last value while mem_we=0)
//   mem_wdata  write data    (holds last value while mem_we=0)
//   busy       frame in progress, through the done cycle
//   done       one-cycle pulse at end of frame
//   error      checksum mismatch on the last frame; sticky until next A5
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | hunting for the A5 sync byte, other bytes discarded
// S_HDR   | collecting ADDR_LO, ADDR_HI, CNT_LO, CNT_HI
// S_DATA  | shifting data bytes into the word lanes
// S_WRITE | single write cycle, input stalled
// S_CSUM  | waiting for the checksum byte
module mem_loader #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int LANES = DWIDTH / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [7:0]    SYNC      = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        hdr_cnt;
  logic [7:0]        lo_byte;
  logic [15:0]       hdr_word;
  logic [LW-1:0]     lane;
  logic [DWIDTH-1:0] word;
  logic [AWIDTH-1:0] addr;
  logic [15:0]       remaining;
  logic [7:0]        sum;
  logic [7:0]        sum_nx;
  logic              done_q;
  logic              error_q;
  logic              accept;

  assign in_ready = (state != S_WRITE) && !reset;
  assign accept   = in_valid && in_ready;
  // Header fields arrive low byte first; the high byte completes the field
  // on the same edge it is accepted.
  assign hdr_word = {in_data, lo_byte};
  assign sum_nx   = sum + in_data;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && in_data == SYNC) state_nx = S_HDR;
      S_HDR:   if (accept && hdr_cnt == 2'd3)
                 state_nx = (hdr_word == 16'd0) ? S_CSUM : S_DATA;
      S_DATA:  if (accept && lane == LAST_LANE) state_nx = S_WRITE;
      S_WRITE: state_nx = (remaining == 16'd1) ? S_CSUM : S_DATA;
      S_CSUM:  if (accept) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hdr_cnt   <= 2'd0;
      lo_byte   <= 8'd0;
      lane      <= '0;
      word      <= '0;
      addr      <= '0;
      remaining <= 16'd0;
      sum       <= 8'd0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && in_data == SYNC) begin
            sum     <= 8'd0;
            error_q <= 1'b0;
            hdr_cnt <= 2'd0;
            lane    <= '0;
          end
        end
        S_HDR: begin
          if (accept) begin
            sum     <= sum_nx;
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd0:    lo_byte   <= in_data;
              2'd1:    addr      <= hdr_word[AWIDTH-1:0];
              2'd2:    lo_byte   <= in_data;
              default: remaining <= hdr_word;
            endcase
          end
        end
        S_DATA: begin
          if (accept) begin
            sum                    <= sum_nx;
            word[int'(lane)*8 +: 8] <= in_data;
            lane                   <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
          end
        end
        S_WRITE: begin
          // addr is AWIDTH bits wide, so the increment wraps by itself
          addr      <= addr + 1'b1;
          remaining <= remaining - 16'd1;
        end
        S_CSUM: begin
          if (accept) begin
            sum    <= sum_nx;
            done_q <= 1'b1;
            if (sum_nx != 8'd0) error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = (state == S_WRITE) && !reset;
  assign mem_addr  = addr;
  assign mem_wdata = word;
  assign busy      = ((state != S_IDLE) || done_q) && !reset;
  assign done      = done_q && !reset;
  assign error     = error_q && !reset;

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  mem_loader #(.DWIDTH(16), .AWIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // observation log, filled on the falling edge
  logic [7:0]  we_addr[$];
  logic [15:0] we_data[$];
  int   cyc = 0;
  int   acc_cyc, done_cnt, done_cyc, lat_bad, ready_low, ready_we_bad;
  logic busy_at_done, busy_after_done, prev_done;
  int   last_wait;
  logic [7:0] frm[$];

  always @(negedge clk) begin
    if (mem_we) begin
      we_addr.push_back(mem_addr);
      we_data.push_back(mem_wdata);
      if (acc_cyc != cyc - 1) lat_bad++;
    end
    if (in_valid && in_ready) acc_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (prev_done) busy_after_done = busy;
    prev_done = done;
    if (!reset) begin
      if (!in_ready) ready_low++;
      if (in_ready == mem_we) ready_we_bad++;
    end
    cyc++;
  end

  task clear_log();
    we_addr.delete();
    we_data.delete();
    acc_cyc = -10; done_cnt = 0; done_cyc = -10; lat_bad = 0;
    ready_low = 0; ready_we_bad = 0;
    busy_at_done = 1'bx; busy_after_done = 1'bx; prev_done = 1'b0;
  endtask

  task send_byte(input logic [7:0] b);
    int w;
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (w >= 20) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout byte=%02h in_ready stuck at %b, required 1", b, in_ready);
    end
    last_wait = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task send_frame(input int first, input bit gaps);
    for (int i = first; i < frm.size(); i++) begin
      send_byte(frm[i]);
      if (gaps && i < frm.size() - 1)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task load_s1(input logic [7:0] csum);
    frm = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, csum};
  endtask

  task test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    n_cmp++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL rst_flags busy/done/error got %b want 000", {busy, done, error}); end
    n_cmp++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_addr_data got %02h/%04h want 00/0000", mem_addr, mem_wdata); end
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
  endtask

  task test_basic();
    clear_log();
    load_s1(8'hDA);
    send_byte(frm[0]);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_sync got %b want 1", busy); end
    send_frame(1, 1'b0);
    settle();
    n_cmp++; if (we_addr.size() !== 2) begin n_fail++; $display("FAIL basic_we_count got %0d want 2", we_addr.size()); end
    n_cmp++; if (we_addr[0] !== 8'h10 || we_data[0] !== 16'h1234) begin n_fail++; $display("FAIL basic_write0 got %04h@%02h want 1234@10", we_data[0], we_addr[0]); end
    n_cmp++; if (we_addr[1] !== 8'h11 || we_data[1] !== 16'h5678) begin n_fail++; $display("FAIL basic_write1 got %04h@%02h want 5678@11", we_data[1], we_addr[1]); end
    n_cmp++; if (ready_low !== 2 || ready_we_bad !== 0) begin n_fail++; $display("FAIL basic_ready_low got %0d low, %0d non-write lows/highs want 2, 0", ready_low, ready_we_bad); end
    n_cmp++; if (lat_bad !== 0) begin n_fail++; $display("FAIL basic_write_latency got %0d late writes want 0", lat_bad); end
    n_cmp++; if (done_cnt !== 1 || done_cyc !== acc_cyc + 1) begin n_fail++; $display("FAIL basic_done got %0d pulses at +%0d want 1 at +1", done_cnt, done_cyc - acc_cyc); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error got %b want 0", error); end
    n_cmp++; if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got %b,%b want 1,0", busy_at_done, busy_after_done); end
  endtask

  task test_wrap();
    clear_log();
    frm = '{8'hA5, 8'hFF, 8'h00, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hFE, 8'hCA, 8'h8A};
    send_frame(0, 1'b0);
    settle();
    n_cmp++; if (we_addr.size() !== 2) begin n_fail++; $display("FAIL wrap_we_count got %0d want 2", we_addr.size()); end
    n_cmp++; if (we_addr[0] !== 8'hFF || we_data[0] !== 16'hBEEF) begin n_fail++; $display("FAIL wrap_write0 got %04h@%02h want BEEF@FF", we_data[0], we_addr[0]); end
    n_cmp++; if (we_addr[1] !== 8'h00 || we_data[1] !== 16'hCAFE) begin n_fail++; $display("FAIL wrap_write1 got %04h@%02h want CAFE@00", we_data[1], we_addr[1]); end
    n_cmp++; if (done_cnt !== 1 || error !== 1'b0) begin n_fail++; $display("FAIL wrap_done_error got %0d pulses err=%b want 1 err=0", done_cnt, error); end
  endtask

  task test_bad_csum();
    clear_log();
    load_s1(8'hDB);
    send_frame(0, 1'b0);
    settle();
    n_cmp++; if (we_addr.size() !== 2 || we_data[0] !== 16'h1234 || we_data[1] !== 16'h5678) begin n_fail++; $display("FAIL bad_writes got %0d writes %04h,%04h want 2 writes 1234,5678", we_addr.size(), we_data[0], we_data[1]); end
    n_cmp++; if (done_cnt !== 1 || error !== 1'b1) begin n_fail++; $display("FAIL bad_done_error got %0d pulses err=%b want 1 err=1", done_cnt, error); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL bad_error_sticky got %b want 1", error); end
    clear_log();
    load_s1(8'hDA);
    send_byte(frm[0]);
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL bad_sync_clears_error got %b want 0", error); end
    send_frame(1, 1'b0);
    settle();
    n_cmp++; if (we_addr.size() !== 2 || done_cnt !== 1 || error !== 1'b0) begin n_fail++; $display("FAIL bad_recovery got %0d writes %0d done err=%b want 2 1 0", we_addr.size(), done_cnt, error); end
  endtask

  task test_zero_count();
    clear_log();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0, 1'b0);
    settle();
    n_cmp++; if (we_addr.size() !== 0) begin n_fail++; $display("FAIL zero_no_write got %0d writes want 0", we_addr.size()); end
    n_cmp++; if (done_cnt !== 1 || done_cyc !== acc_cyc + 1) begin n_fail++; $display("FAIL zero_done got %0d pulses at +%0d want 1 at +1", done_cnt, done_cyc - acc_cyc); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL zero_error got %b want 0", error); end
  endtask

  task test_gaps();
    logic [7:0] junk[3];
    junk = '{8'h00, 8'hFF, 8'h5A};
    clear_log();
    for (int i = 0; i < 3; i++) begin
      send_byte(junk[i]);
      n_cmp++; if (last_wait !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL gaps_junk%0d got wait=%0d busy=%b want 0 0", i, last_wait, busy); end
    end
    load_s1(8'hDA);
    send_frame(0, 1'b1);
    settle();
    n_cmp++; if (we_addr.size() !== 2) begin n_fail++; $display("FAIL gaps_we_count got %0d want 2", we_addr.size()); end
    n_cmp++; if (we_addr[0] !== 8'h10 || we_data[0] !== 16'h1234 || we_addr[1] !== 8'h11 || we_data[1] !== 16'h5678) begin n_fail++; $display("FAIL gaps_writes got %04h@%02h %04h@%02h want 1234@10 5678@11", we_data[0], we_addr[0], we_data[1], we_addr[1]); end
    n_cmp++; if (done_cnt !== 1 || done_cyc !== acc_cyc + 1 || error !== 1'b0) begin n_fail++; $display("FAIL gaps_done got %0d pulses at +%0d err=%b want 1 at +1 err=0", done_cnt, done_cyc - acc_cyc, error); end
  endtask

  task test_reset_mid();
    clear_log();
    load_s1(8'hDA);
    for (int i = 0; i < 6; i++) send_byte(frm[i]);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({in_ready, mem_we, busy, done, error} !== 5'b00000) begin n_fail++; $display("FAIL mid_rst_outputs got %b want 00000", {in_ready, mem_we, busy, done, error}); end
    n_cmp++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_addr_data got %02h/%04h want 00/0000", mem_addr, mem_wdata); end
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_release got ready=%b busy=%b want 1 0", in_ready, busy); end
    settle();
    n_cmp++; if (we_addr.size() !== 0) begin n_fail++; $display("FAIL mid_no_write got %0d writes want 0", we_addr.size()); end
    clear_log();
    send_frame(0, 1'b0);
    settle();
    n_cmp++; if (we_addr.size() !== 2 || we_addr[0] !== 8'h10 || we_data[0] !== 16'h1234 || we_addr[1] !== 8'h11 || we_data[1] !== 16'h5678) begin n_fail++; $display("FAIL mid_resend_writes got %0d writes %04h@%02h %04h@%02h want 1234@10 5678@11", we_addr.size(), we_data[0], we_addr[0], we_data[1], we_addr[1]); end
    n_cmp++; if (done_cnt !== 1 || error !== 1'b0) begin n_fail++; $display("FAIL mid_resend_done got %0d pulses err=%b want 1 err=0", done_cnt, error); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_wrap();
    test_bad_csum();
    test_zero_count();
    test_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Writer-side companion to the team's read-only memories.
- Receives a framed byte stream (from a UART or a debug port) and assembles little-endian DWIDTH-bit words.
- Writes those words into a synchronous RAM through a simple write port.
- Used to load program and data images at run time instead of at elaboration.

Parameters:
DWIDTH, 16, memory word width in bits; must be a multiple of 8 (8..64)
AWIDTH, 8, memory address width in bits; must be 1..16

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
in_data  input  8  incoming byte
in_valid  input  1  in_data holds a byte
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  write strobe, one cycle per word
mem_addr  output  AWIDTH  write address
mem_wdata  output  DWIDTH  write data
busy  output  1  a frame is in progress (sync byte accepted, done not yet pulsed)
done  output  1  one-cycle pulse at end of frame
error  output  1  checksum mismatch on last frame; sticky

Behaviour:
- Byte accept: a byte is accepted on a rising edge where in_valid && in_ready. Nothing else consumes input.
- Frame format, in byte order:
  - 0xA5 sync byte
  - ADDR_LO, ADDR_HI: 16-bit start address, truncated to AWIDTH
  - CNT_LO, CNT_HI: 16-bit word count N
  - N*(DWIDTH/8) data bytes, each word least-significant byte first
  - CSUM byte
- Checksum rule: the 8-bit sum of every byte after the sync byte, CSUM included, must equal 0x00 (mod 256).
- States and transitions:
  - IDLE: bytes other than 0xA5 are accepted and discarded. Accepting 0xA5 clears error, clears the running sum, and goes to HDR.
  - HDR: accepts exactly 4 bytes (2-bit counter). After the 4th byte: N==0 goes to CSUM, otherwise goes to DATA.
  - DATA: shifts bytes into the word register at byte lanes 0..DWIDTH/8-1. Accepting the last lane goes to WRITE.
  - WRITE: lasts exactly one cycle. in_ready=0, mem_we=1, with mem_addr = current address and mem_wdata = assembled word. On exit:
    - address increments modulo 2^AWIDTH (wraps 2^AWIDTH-1 -> 0)
    - remaining count decrements
    - remaining==0 goes to CSUM, otherwise goes to DATA
  - CSUM: accepting the byte goes to IDLE. In the same edge, done<=1 for exactly one cycle, and error<=1 if the final sum != 0.
- in_ready is 1 in IDLE, HDR, DATA and CSUM; it is 0 in WRITE and during the reset cycle.
- Write latency: mem_we is asserted in the cycle immediately after the edge that accepted the word's last byte.
- A checksum failure does not undo writes; error only reports the failure.
- busy is 1 from the cycle after the sync byte is accepted through the cycle in which done is high. It is 0 in IDLE otherwise.
- in_valid gaps are permitted anywhere; the state holds and no timeout exists.
- mem_addr and mem_wdata are don't-care while mem_we=0. Implementations hold the last value.
- Reset values: state=IDLE, in_ready=0 during reset, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, sum=0, counters=0.
- Reset mid-frame: the partial word is discarded and no mem_we is issued. The first cycle after reset deasserts is IDLE with in_ready=1.
- A sync byte appearing inside a frame is treated as ordinary data or header.
- Throughput: one word per (DWIDTH/8)+1 cycles with in_valid held high.

Test Plan:
1. Basic frame (DWIDTH=16, AWIDTH=8): send A5 10 00 02 00 34 12 78 56 DA with in_valid=1 continuously.
   - Expect mem_we at addr 0x10 with data 0x1234, then at addr 0x11 with data 0x5678.
   - Expect in_ready=0 exactly in those two write cycles.
   - Expect done pulsing once after DA, error=0, busy falling with done.
2. Address wrap: send A5 FF 00 02 00 EF BE FE CA 8A.
   - Expect writes 0xBEEF@0xFF and 0xCAFE@0x00, done=1, error=0.
3. Bad checksum: repeat scenario 1 with a final byte of 0xDB.
   - Both writes still occur, done pulses, and error=1 and stays 1.
   - A following valid frame's A5 clears error in the next cycle.
4. Zero count: send A5 00 00 00 00 00.
   - Expect no mem_we, done pulses one cycle after the final byte, error=0.
5. Garbage and gaps: send 00 FF 5A, then scenario 1 with in_valid deasserted for 1-3 random cycles between bytes.
   - The leading bytes are discarded with in_ready=1 and no busy.
   - Writes and done match scenario 1 exactly.
6. Reset mid-DATA: assert reset for 1 cycle after byte 0x34 of scenario 1.
   - Expect no mem_we, and all outputs at their reset values during reset.
   - Resending scenario 1 in full then completes correctly.
